clock_config_tx: RTL and testbench

//  Serial transmitter for the slow-clock divider configuration link. Accepts a DATA_W-bit
//  max-count word over a valid/ready handshake and serialises it LSB-first onto the

---
 rtl/clock_config_if.sv | 33 +++
 rtl/clock_config_tx.sv | 120 ++++++++++++
 tb/tb_clock_config_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_config_if.sv
// Config-word handshake plus the serial link toward the clock divider.
// The master modport is the config-logic side; the slave modport is the transmitter.
interface clock_config_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              clock_change_mode;
    logic              clock_max_count;
    logic              busy;
    logic              done;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  clock_change_mode,
        input  clock_max_count,
        input  busy,
        input  done
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output clock_change_mode,
        output clock_max_count,
        output busy,
        output done
    );
endinterface

// File: rtl/clock_config_tx.sv
// Serialises a DATA_W-bit max-count word LSB-first under a mode-high envelope for the
// clock divider: LEAD filler cycles, DATA_W data cycles, then GAP idle cycles.
module clock_config_tx #(
    parameter int DATA_W = 32,
    parameter int LEAD   = 2,
    parameter int GAP    = 2
) (
    input  logic           clk,
    input  logic           rst,
    clock_config_if.slave  cfg
);
    localparam int LEAD_CW = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam int BIT_CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_CW  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LEAD_CW-1:0] LEAD_LAST = LEAD_CW'(LEAD - 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(DATA_W - 1);
    localparam logic [GAP_CW-1:0]  GAP_LAST  = GAP_CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [LEAD_CW-1:0]  lead_cnt_r;
    logic [BIT_CW-1:0]   bit_cnt_r;
    logic [GAP_CW-1:0]   gap_cnt_r;
    logic                ready_r;
    logic                mode_r;
    logic                data_r;
    logic                busy_r;
    logic                done_r;

    // Frame sequencer: every output is a register updated on the state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            lead_cnt_r <= '0;
            bit_cnt_r  <= '0;
            gap_cnt_r  <= '0;
            ready_r    <= 1'b0;
            mode_r     <= 1'b0;
            data_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mode_r <= 1'b0;
                    data_r <= 1'b0;
                    done_r <= 1'b0;
                    if (ready_r && cfg.cfg_valid) begin
                        shreg_r    <= cfg.cfg_data;
                        lead_cnt_r <= '0;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        mode_r     <= 1'b1;
                        state_r    <= ST_LEAD;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                // Filler cycles give the receiver time to see the envelope edge and clear its index.
                ST_LEAD: begin
                    if (lead_cnt_r == LEAD_LAST) begin
                        data_r    <= shreg_r[0];
                        shreg_r   <= {1'b0, shreg_r[DATA_W-1:1]};
                        bit_cnt_r <= '0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        lead_cnt_r <= lead_cnt_r + LEAD_CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        mode_r    <= 1'b0;
                        data_r    <= 1'b0;
                        done_r    <= 1'b1;
                        gap_cnt_r <= '0;
                        state_r   <= ST_GAP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
                        data_r    <= shreg_r[0];
                        shreg_r   <= {1'b0, shreg_r[DATA_W-1:1]};
                    end
                end
                ST_GAP: begin
                    done_r <= 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    mode_r  <= 1'b0;
                    data_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready         = ready_r;
    assign cfg.clock_change_mode = mode_r;
    assign cfg.clock_max_count   = data_r;
    assign cfg.busy              = busy_r;
    assign cfg.done              = done_r;
endmodule

// File: tb/tb_clock_config_tx.sv
// Directed bench for clock_config_tx: a frame-timing model checks dut1 every cycle,
// and literal expectations pin frame length, received words and spacing on both instances.
module tb_clock_config_tx;
    localparam int DW   = 32;
    localparam int LEAD = 2;
    localparam int GAP  = 2;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    clock_config_if #(.DATA_W(DW)) if1 ();
    clock_config_if #(.DATA_W(DW)) if2 ();

    clock_config_tx #(.DATA_W(DW), .LEAD(LEAD), .GAP(GAP)) dut1 (.clk(clk), .rst(rst), .cfg(if1));
    clock_config_tx #(.DATA_W(DW), .LEAD(1), .GAP(1))       dut2 (.clk(clk), .rst(rst), .cfg(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Model: k counts clock edges since the accept edge of the current frame.
    bit          m_act = 1'b0;
    bit          m_rdy = 1'b0;
    int          m_k   = 0;
    logic [31:0] m_word = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            m_rdy = 1'b0;
        end else begin
            if (m_act) begin
                m_k++;
                if (m_k == LEAD + DW + GAP) m_act = 1'b0;
            end else if (m_rdy && if1.cfg_valid) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_word = if1.cfg_data;
            end
            m_rdy = !m_act;
        end
    end

    always @(negedge clk) begin
        logic e_mode, e_data, e_done;
        e_mode = m_act && (m_k < LEAD + DW);
        e_data = (m_act && m_k >= LEAD && m_k < LEAD + DW) ? m_word[m_k - LEAD] : 1'b0;
        e_done = m_act && (m_k == LEAD + DW);
        chk("cyc_ready", 32'(if1.cfg_ready), 32'(m_rdy));
        chk("cyc_mode",  32'(if1.clock_change_mode), 32'(e_mode));
        chk("cyc_data",  32'(if1.clock_max_count), 32'(e_data));
        chk("cyc_busy",  32'(if1.busy), 32'(m_act));
        chk("cyc_done",  32'(if1.done), 32'(e_done));
    end

    function automatic logic mode_of(input bit sel);
        return sel ? if2.clock_change_mode : if1.clock_change_mode;
    endfunction
    function automatic logic dat_of(input bit sel);
        return sel ? if2.clock_max_count : if1.clock_max_count;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? if2.done : if1.done;
    endfunction
    function automatic logic rdy_of(input bit sel);
        return sel ? if2.cfg_ready : if1.cfg_ready;
    endfunction

    task automatic wait_ready(input bit sel);
        int n = 0;
        while (rdy_of(sel) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_ready_timeout", 32'(rdy_of(sel)), 32'd1);
    endtask

    task automatic send(input bit sel, input logic [31:0] w);
        wait_ready(sel);
        if (sel) begin if2.cfg_valid = 1'b1; if2.cfg_data = w; end
        else     begin if1.cfg_valid = 1'b1; if1.cfg_data = w; end
        @(negedge clk);
        if (sel) if2.cfg_valid = 1'b0;
        else     if1.cfg_valid = 1'b0;
    endtask

    // Receiver stand-in: shift in every envelope-high bit; the last DW bits form the word.
    task automatic measure(input bit sel, output int hi, output logic [31:0] rx);
        int low = 0;
        hi = 0;
        rx = 32'd0;
        while (mode_of(sel) !== 1'b1 && low < 300) begin
            low++;
            @(negedge clk);
        end
        while (mode_of(sel) === 1'b1 && hi < 300) begin
            hi++;
            rx = {dat_of(sel), rx[31:1]};
            @(negedge clk);
        end
        chk("done_at_drop", 32'(done_of(sel)), 32'd1);
    endtask

    int          hi;
    int          lo;
    int          gap_busy;
    int          n;
    logic [31:0] rx;
    int          dq[$];

    initial begin
        rst = 1'b1;
        if1.cfg_valid = 1'b0; if1.cfg_data = 32'd0;
        if2.cfg_valid = 1'b0; if2.cfg_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(if1.cfg_ready), 32'd0);
        chk("rst_mode",  32'(if1.clock_change_mode), 32'd0);
        chk("rst_busy",  32'(if1.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(if1.cfg_ready), 32'd1);

        // Small word, then ready returns after the two GAP cycles.
        send(1'b0, 32'h0000_0005);
        measure(1'b0, hi, rx);
        chk("t1_env", 32'(hi), 32'd34);
        chk("t1_word", rx, 32'h0000_0005);
        chk("t1_ready_gap0", 32'(if1.cfg_ready), 32'd0);
        @(negedge clk);
        chk("t1_ready_gap1", 32'(if1.cfg_ready), 32'd0);
        @(negedge clk);
        chk("t1_ready_back", 32'(if1.cfg_ready), 32'd1);
        chk("t1_busy_clear", 32'(if1.busy), 32'd0);

        send(1'b0, 32'hA5A5_F00F);
        measure(1'b0, hi, rx);
        chk("t2_env", 32'(hi), 32'd34);
        chk("t2_word", rx, 32'hA5A5_F00F);

        // Valid held high with data changing every cycle.
        wait_ready(1'b0);
        if1.cfg_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if1.cfg_data = 32'h3C00_0000 + 32'(i) * 32'h0001_0101;
            @(negedge clk);
            if (if1.done === 1'b1) dq.push_back(i);
        end
        if1.cfg_valid = 1'b0;
        chk("t3_frames", 32'(dq.size()), 32'd3);
        if (dq.size() >= 3) begin
            chk("t3_period0", 32'(dq[1] - dq[0]), 32'd37);
            chk("t3_period1", 32'(dq[2] - dq[1]), 32'd37);
        end

        // Reset while bit 10 is on the wire, then resend.
        send(1'b0, 32'hDEAD_BEEF);
        repeat (12) @(negedge clk);
        chk("t4_bit10", 32'(if1.clock_max_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_mode", 32'(if1.clock_change_mode), 32'd0);
        chk("t4_data", 32'(if1.clock_max_count), 32'd0);
        chk("t4_done", 32'(if1.done), 32'd0);
        chk("t4_busy", 32'(if1.busy), 32'd0);
        chk("t4_ready_in_rst", 32'(if1.cfg_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_after", 32'(if1.cfg_ready), 32'd1);
        chk("t4_no_done", 32'(if1.done), 32'd0);
        send(1'b0, 32'h1234_5678);
        measure(1'b0, hi, rx);
        chk("t4_env", 32'(hi), 32'd34);
        chk("t4_word", rx, 32'h1234_5678);

        // All-zero then all-one words back to back.
        wait_ready(1'b0);
        if1.cfg_valid = 1'b1;
        if1.cfg_data  = 32'h0000_0000;
        @(negedge clk);
        if1.cfg_data  = 32'hFFFF_FFFF;
        measure(1'b0, hi, rx);
        chk("t5_env0", 32'(hi), 32'd34);
        chk("t5_word0", rx, 32'h0000_0000);
        lo = 0;
        gap_busy = 0;
        while (if1.clock_change_mode !== 1'b1 && lo < 20) begin
            if (if1.busy === 1'b1) gap_busy++;
            lo++;
            @(negedge clk);
        end
        chk("t5_low_between", 32'(lo), 32'd3);
        chk("t5_gap_cycles", 32'(gap_busy), 32'd2);
        measure(1'b0, hi, rx);
        if1.cfg_valid = 1'b0;
        chk("t5_env1", 32'(hi), 32'd34);
        chk("t5_word1", rx, 32'hFFFF_FFFF);

        // Instance with LEAD=1, GAP=1.
        send(1'b1, 32'h8000_0001);
        measure(1'b1, hi, rx);
        chk("t6_env", 32'(hi), 32'd33);
        chk("t6_word", rx, 32'h8000_0001);
        wait_ready(1'b1);
        dq.delete();
        if2.cfg_valid = 1'b1;
        if2.cfg_data  = 32'h0F0F_3C3C;
        n = 0;
        while (n < 80) begin
            @(negedge clk);
            if (if2.done === 1'b1) dq.push_back(n);
            n++;
        end
        if2.cfg_valid = 1'b0;
        chk("t6_frames", 32'(dq.size()), 32'd2);
        if (dq.size() >= 2) chk("t6_period", 32'(dq[1] - dq[0]), 32'd35);

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
